// File: rtl/stream_cipher.sv
// Byte-wide stream cipher: dout = din XOR AES_SBOX[(key + byte index) mod 256], one cycle latency.
// Optional STREAM_CIPHER_NOKEY_BLOCK_EN: ignore data until a key has been loaded.
module stream_cipher (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  input  logic [7:0] key,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic [7:0] dout,
  output logic       dout_valid
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [7:0] ks_idx;
  logic [7:0] idx_sel;
  logic       accept;

  // A key arriving with data applies to that same byte.
  assign idx_sel = key_in ? key : ks_idx;

`ifdef STREAM_CIPHER_NOKEY_BLOCK_EN
  logic key_loaded;

  assign accept = din_valid & (key_in | key_loaded);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_loaded <= 1'b0;
    end else if (key_in) begin
      key_loaded <= 1'b1;
    end
  end
`else
  assign accept = din_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_idx     <= 8'h00;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
    end else if (accept) begin
      dout       <= din ^ SBOX[idx_sel];
      dout_valid <= 1'b1;
      ks_idx     <= idx_sel + 8'd1;
    end else begin
      dout_valid <= 1'b0;
      if (key_in) begin
        ks_idx <= key;
      end
    end
  end

endmodule

// File: tb/tb_stream_cipher.sv
// Scoreboard bench for stream_cipher: directed vectors plus a key/byte sweep against a
// GF(2^8) inverse + affine S-box reference.
`timescale 1ns/1ps
module tb_stream_cipher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_in = 1'b0;
  logic [7:0] key = 8'h00;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];
  logic [7:0] ref_sbox [256];

  stream_cipher dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key(key),
    .din(din), .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      ref_sbox[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every presented byte must match the oldest expected value.
  always @(posedge clk) begin
    #1;
    if (rst_n && dout_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h with nothing expected", dout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL dout_data: got %h expected %h", dout, e);
        end
      end
    end
  end

  task automatic drive(input logic ki, input logic [7:0] k, input logic dv, input logic [7:0] d,
                       input logic [7:0] exp);
    @(negedge clk);
    key_in = ki; key = k; din_valid = dv; din = d;
    if (dv) exp_q.push_back(exp);
  endtask

  task automatic load_key(input logic [7:0] k);
    drive(1'b1, k, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] exp);
    drive(1'b0, 8'h00, 1'b1, d, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_in = 1'b0; din_valid = 1'b0; din = 8'hxx;
      @(posedge clk);
      #2;
      chk("idle_valid_low", {7'b0, dout_valid}, 8'h00);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] keys [4];
    build_sbox();
    chk("ref_sbox_00", ref_sbox[8'h00], 8'h63);
    chk("ref_sbox_52", ref_sbox[8'h52], 8'h00);

    #3;
    chk("reset_dout", dout, 8'h00);
    chk("reset_valid", {7'b0, dout_valid}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back from key 0x00.
    load_key(8'h00);
    send(8'h00, 8'h63);
    send(8'h01, 8'h7d);
    idle(1);

    // Encrypt then decrypt by re-keying.
    load_key(8'h41);
    send(8'h41, 8'hc2);
    load_key(8'h41);
    send(8'hc2, 8'h41);
    idle(1);

    // Index wrap 0xFF -> 0x00.
    load_key(8'hff);
    send(8'h00, 8'h16);
    send(8'h00, 8'h63);
    idle(1);

    // Idle cycles do not advance the keystream.
    load_key(8'h00);
    send(8'h00, 8'h63);
    idle(3);
    send(8'h00, 8'h7c);
    idle(1);

    // Key and data on the same edge.
    drive(1'b1, 8'h01, 1'b1, 8'h00, 8'h7c);
    send(8'h00, 8'h77);
    idle(1);

    // Full sweep, back-to-back.
    for (int k = 0; k < 256; k++) begin
      load_key(8'(k));
      for (int b = 0; b < 256; b++)
        send(8'(b), 8'(b) ^ ref_sbox[8'(k + b)]);
    end
    idle(1);

    // Same stream with random gaps on a few keys.
    keys[0] = 8'h00; keys[1] = 8'h5a; keys[2] = 8'ha5; keys[3] = 8'hff;
    for (int i = 0; i < 4; i++) begin
      load_key(keys[i]);
      for (int b = 0; b < 256; b++) begin
        send(8'(b), 8'(b) ^ ref_sbox[8'(keys[i] + 8'(b))]);
        idle(int'($urandom_range(0, 5)));
      end
    end
    idle(1);

    // Asynchronous reset mid-stream clears outputs without a clock edge.
    load_key(8'h37);
    send(8'h00, ref_sbox[8'h37]);
    @(negedge clk);
    key_in = 1'b0; din_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {7'b0, dout_valid}, 8'h00);
    chk("async_reset_dout", dout, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    // Key discarded: stream restarts at index 0x00.
    send(8'h00, 8'h63);
    idle(2);

    chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
